// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter and read-forwarding controller for a 32x32 register file.
// Two writeback requesters (req0 = ALU, req1 = load) share the single write
// port round-robin. The winning write is registered into an output stage that
// drives the register file, and reads are forwarded from that stage.
module regfile_wb_arbiter #(
    parameter int AW                 = 5,
    parameter int DW                 = 32,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_a3,
    output logic [DW-1:0] rf_wd,
    input  logic [AW-1:0] rd_a1,
    input  logic [AW-1:0] rd_a2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2
);

    // 1 = requester 1 won the most recent transfer, so requester 0 wins next conflict
    logic          last_grant_reg;
    logic          rf_we_reg;
    logic [AW-1:0] rf_a3_reg;
    logic [DW-1:0] rf_wd_reg;

    logic          grant0;
    logic          grant1;
    logic          xfer;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;
    logic          win_is_zero;

    // Round-robin grant from the current cycle's valids; stall and reset block it
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && !hold) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_reg;
                grant1 = !last_grant_reg;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // A grant is only ever issued to a valid requester, so grant implies transfer
    assign xfer        = grant0 | grant1;
    assign win_addr    = grant1 ? req1_addr : req0_addr;
    assign win_data    = grant1 ? req1_data : req0_data;
    assign win_is_zero = ZERO_REG_HARDWIRED && (win_addr == '0);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Output stage: capture the winning write, retire it after one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
            rf_we_reg      <= 1'b0;
            rf_a3_reg      <= '0;
            rf_wd_reg      <= '0;
        end else if (xfer) begin
            last_grant_reg <= grant1;
            rf_a3_reg      <= win_addr;
            rf_wd_reg      <= win_data;
            rf_we_reg      <= !win_is_zero;
        end else begin
            rf_we_reg      <= 1'b0;
        end
    end

    assign rf_we = rf_we_reg;
    assign rf_a3 = rf_a3_reg;
    assign rf_wd = rf_wd_reg;

    // Forwarding: the write in the output stage is not yet in the array, so
    // a matching read takes the staged data instead of the array output
    logic [AW-1:0] rd_addr [2];
    logic [DW-1:0] rd_raw  [2];
    logic [DW-1:0] rd_fwd  [2];

    assign rd_addr[0] = rd_a1;
    assign rd_addr[1] = rd_a2;
    assign rd_raw[0]  = rf_rd1;
    assign rd_raw[1]  = rf_rd2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign rd_fwd[gi] = (rf_we_reg && (rf_a3_reg == rd_addr[gi])) ? rf_wd_reg : rd_raw[gi];
        end
    endgenerate

    assign rd1 = rd_fwd[0];
    assign rd2 = rd_fwd[1];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural model, a small
// register-file array fed by the write port, and per-cycle output checking.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [4:0]  rd_a1, rd_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic [31:0] rd1, rd2;

    // read-data override, used where a test dictates the array output directly
    logic        ovr;
    logic [31:0] ovr_rd1, ovr_rd2;
    logic [31:0] mem [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.AW(5), .DW(32), .ZERO_REG_HARDWIRED(1'b1)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .rd_a1(rd_a1), .rd_a2(rd_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rd1(rd1), .rd2(rd2)
    );

    // Register file: async read, write on the rising edge
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
        end else if (rf_we) begin
            mem[rf_a3] <= rf_wd;
        end
    end
    assign rf_rd1 = ovr ? ovr_rd1 : mem[rd_a1];
    assign rf_rd2 = ovr ? ovr_rd2 : mem[rd_a2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_ok = 1'b0;
    int          m_last;      // index of the requester that won the most recent transfer
    bit          m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;

    // which requester the rules pick this cycle, -1 for none
    function automatic int pick();
        if (reset || hold) return -1;
        if (req0_valid && req1_valid) return 1 - m_last;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        w = pick();
        if (reset) begin
            m_ok   <= 1'b1;
            m_last <= 1;
            m_we   <= 1'b0;
            m_a3   <= 5'd0;
            m_wd   <= 32'd0;
        end else if (w >= 0) begin
            m_last <= w;
            m_a3   <= (w == 1) ? req1_addr : req0_addr;
            m_wd   <= (w == 1) ? req1_data : req0_data;
            m_we   <= (((w == 1) ? req1_addr : req0_addr) != 5'd0);
            $display("xfer req%0d addr=%0d data=%h", w, (w == 1) ? req1_addr : req0_addr,
                     (w == 1) ? req1_data : req0_data);
        end else begin
            m_we   <= 1'b0;
        end
    end

    // Compare every cycle once the model has seen a reset edge
    always @(negedge clk) begin
        int w;
        if (m_ok) begin
            w = pick();
            chk("req0_ready", 32'(req0_ready), 32'(w == 0));
            chk("req1_ready", 32'(req1_ready), 32'(w == 1));
            chk("rf_we", 32'(rf_we), 32'(m_we));
            chk("rf_a3", 32'(rf_a3), 32'(m_a3));
            chk("rf_wd", rf_wd, m_wd);
            chk("rd1", rd1, (m_we && m_a3 == rd_a1) ? m_wd : rf_rd1);
            chk("rd2", rd2, (m_we && m_a3 == rd_a2) ? m_wd : rf_rd2);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'h0;
        rd_a1 = 5'd0; rd_a2 = 5'd0;
        ovr = 1'b0; ovr_rd1 = 32'h0; ovr_rd2 = 32'h0;

        // 1: reset with req0 pending
        cyc(); cyc();
        @(negedge clk);
        chk("t1_we", 32'(rf_we), 32'd0);
        chk("t1_a3", 32'(rf_a3), 32'd0);
        chk("t1_wd", rf_wd, 32'd0);
        chk("t1_ready0", 32'(req0_ready), 32'd0);
        cyc(); reset = 1'b0;
        @(negedge clk);
        chk("t1_ready0_rel", 32'(req0_ready), 32'd1);
        cyc(); req0_valid = 1'b0;

        // 2: single write, latency and array contents
        cyc(); req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t2_ready0", 32'(req0_ready), 32'd1);
        cyc(); req0_valid = 1'b0;
        @(negedge clk);
        chk("t2_we", 32'(rf_we), 32'd1);
        chk("t2_a3", 32'(rf_a3), 32'd5);
        chk("t2_wd", rf_wd, 32'hDEADBEEF);
        cyc(); rd_a1 = 5'd5;
        @(negedge clk);
        chk("t2_we_off", 32'(rf_we), 32'd0);
        chk("t2_rd1", rd1, 32'hDEADBEEF);

        // precondition: a req1 write so the next conflict goes to req0
        cyc(); req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
        cyc(); req1_valid = 1'b0;

        // 3: both valid for 4 cycles, alternating grants
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            chk("t3_ready1", 32'(req1_ready), 32'(i % 2 == 1));
            if (i > 0) chk("t3_a3", 32'(rf_a3), (i % 2 == 1) ? 32'd1 : 32'd2);
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("t3_a3_last", 32'(rf_a3), 32'd2);

        // 4: forwarding from the output stage
        cyc(); req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h12345678;
        cyc(); req0_valid = 1'b0;
        ovr = 1'b1; ovr_rd1 = 32'h0; ovr_rd2 = 32'h55; rd_a1 = 5'd7; rd_a2 = 5'd8;
        @(negedge clk);
        chk("t4_rd1", rd1, 32'h12345678);
        chk("t4_rd2", rd2, 32'h55);

        // 5: write to register 0 is consumed but never reaches the array
        cyc(); ovr = 1'b0; req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("t5_ready1", 32'(req1_ready), 32'd1);
        cyc(); req1_valid = 1'b0; rd_a1 = 5'd0; ovr = 1'b1; ovr_rd1 = 32'h77;
        @(negedge clk);
        chk("t5_we", 32'(rf_we), 32'd0);
        chk("t5_rd1", rd1, 32'h77);
        cyc(); ovr = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
        @(negedge clk);
        chk("t5_ready0", 32'(req0_ready), 32'd1);
        cyc(); req0_valid = 1'b0;
        @(negedge clk);
        chk("t5_ready1b", 32'(req1_ready), 32'd1);
        cyc(); req1_valid = 1'b0;

        // 6: hold blocks grants and preserves the round-robin pointer
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h100;
        req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h111;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_hold_r0", 32'(req0_ready), 32'd0);
            chk("t6_hold_r1", 32'(req1_ready), 32'd0);
            if (i > 0) chk("t6_hold_we", 32'(rf_we), 32'd0);
            cyc();
        end
        hold = 1'b0;
        @(negedge clk);
        chk("t6_resume_r0", 32'(req0_ready), 32'd1);
        cyc(); req0_valid = 1'b0;
        @(negedge clk);
        chk("t6_resume_r1", 32'(req1_ready), 32'd1);
        cyc(); req1_valid = 1'b0;

        // 7: reset while a write sits in the output stage
        req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hC;
        cyc(); reset = 1'b1; req0_addr = 5'd13; req0_data = 32'hD;
        @(negedge clk);
        chk("t7_ready0_rst", 32'(req0_ready), 32'd0);
        cyc();
        @(negedge clk);
        chk("t7_we", 32'(rf_we), 32'd0);
        chk("t7_a3", 32'(rf_a3), 32'd0);
        cyc(); reset = 1'b0;
        @(negedge clk);
        chk("t7_ready0_rel", 32'(req0_ready), 32'd1);
        cyc(); req0_valid = 1'b0;
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net: the directed run is short and finite
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port arbiter and read-forwarding controller for the 32x32 register file, which has 2 async read ports (A1/RD1, A2/RD2) and 1 write port (A3/WD/WE) written on the clk rising edge.
- Arbitrates two writeback requesters (req0 = ALU writeback, req1 = load writeback) onto the single write port, round-robin, valid/ready handshake.
- Registers the winning write into an output stage that drives the register file write port.
- Forwards the in-flight write data to the read ports so reads never return stale data.

Parameters:
AW, 5, register address width
DW, 32, data width
ZERO_REG_HARDWIRED, 1, when 1, writes to address 0 are consumed but never drive rf_we

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
hold  input  1  pipeline stall; blocks new grants
req0_valid  input  1  requester 0 has a write
req0_addr  input  AW  requester 0 destination register
req0_data  input  DW  requester 0 write data
req0_ready  output  1  requester 0 write accepted this cycle
req1_valid  input  1  requester 1 has a write
req1_addr  input  AW  requester 1 destination register
req1_data  input  DW  requester 1 write data
req1_ready  output  1  requester 1 write accepted this cycle
rf_we  output  1  register file WE
rf_a3  output  AW  register file A3
rf_wd  output  DW  register file WD
rd_a1  input  AW  read address 1 (also driven to register file A1 externally)
rd_a2  input  AW  read address 2
rf_rd1  input  DW  register file RD1
rf_rd2  input  DW  register file RD2
rd1  output  DW  forwarded read data 1
rd2  output  DW  forwarded read data 2

Behaviour:
- Reset (sync, reset=1 at an edge): rf_we=0, rf_a3=0, rf_wd=0, last_grant=1 (so req0 wins the first conflict). While reset=1, req0_ready=req1_ready=0.
- Grant logic is combinational on the current cycle's valids:
  - hold=1 or reset=1: no grant.
  - Only one requester valid: that one is granted.
  - Both valid: grant goes to the requester that is not last_grant.
- reqN_ready = grantN. At most one ready is high per cycle.
- Transfer = valid && ready. A requester holds valid/addr/data stable until its transfer.
- last_grant updates only on a transfer, including a transfer to address 0.
- Output stage, at the edge ending a transfer cycle:
  - rf_a3 <= addr, rf_wd <= data.
  - rf_we <= 1, except rf_we <= 0 when addr==0 and ZERO_REG_HARDWIRED=1.
- No transfer at an edge: rf_we <= 0; rf_a3 and rf_wd hold their values.
- Latency: transfer in cycle N; rf_we/rf_a3/rf_wd valid in cycle N+1; data stored in the register file at the end of cycle N+1 and readable from it in cycle N+2.
- Throughput: 1 write per cycle. No internal queue; a losing requester waits.
- Forwarding (combinational):
  - rd1 = rf_wd if (rf_we && rf_a3==rd_a1), else rf_rd1. rd2 uses the same rule with rd_a2 / rf_rd2.
  - Address 0 never forwards, because rf_we is never set for it when hardwired.
- hold=1: both readies are 0; the output stage retires its current write (rf_we drops to 0 the next cycle); last_grant is unchanged. Arbitration resumes on the first cycle with hold=0.
- Reset mid-operation: a write sitting in the output stage is discarded (rf_we=0 after the reset edge); pending requesters are not accepted until reset deasserts.
- Same address from both requesters on consecutive grants: writes retire in grant order; the later write wins.

Test Plan:
1. Hold reset=1 for 2 cycles with req0_valid=1 -> rf_we=0, rf_a3=0, rf_wd=0, req0_ready=0; after release, req0_ready=1 in the first cycle.
2. Only req0_valid, addr=5, data=0xDEADBEEF -> req0_ready=1 in cycle N; cycle N+1: rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF; cycle N+2: rf_we=0 and register file reads 5 as 0xDEADBEEF.
3. Both valid for 4 cycles (req0 addr=1 data=0xA, req1 addr=2 data=0xB) -> grants go 0,1,0,1; rf_a3 sequence 1,2,1,2; never both ready.
4. Forwarding: while rf_we=1, rf_a3=7, rf_wd=0x12345678, drive rd_a1=7 with rf_rd1=0 -> rd1=0x12345678; same cycle rd_a2=8 with rf_rd2=0x55 -> rd2=0x55.
5. req1 addr=0 data=0xFFFFFFFF -> req1_ready=1, rf_we stays 0, rd1 with rd_a1=0 equals rf_rd1; next conflict grants req0.
6. Both valid, hold=1 for 3 cycles -> both readies 0, rf_we=0 from the second cycle; hold=0 -> grant goes to the requester opposite the pre-hold last_grant.
